// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: md_op encodings, engine FSM states and op-class helpers.
// Included by the decoder and hazard unit as well as the engine itself.
package md_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Bit 0 of every encoding selects the unsigned variant.
  function automatic logic op_is_unsigned(input md_op_e op);
    logic [MD_OP_W-1:0] bits;
    bits = op;
    return bits[0];
  endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring radix-2 unsigned divider: one quotient bit per cycle, WIDTH cycles after load.
// done is high during the cycle in which the final iteration is performed.
module md_divider
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // quot_q doubles as the dividend shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    shifted  = {rem_q, quot_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[WIDTH];
    if (load) begin
      rem_d    = '0;
      quot_d   = dividend;
      dvs_d    = divisor;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], fits};
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (cnt_q == CNT_LAST);
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/md_engine.sv
// Multi-cycle multiply / multiply-accumulate / divide engine owning the HI/LO register pair.
// Multiplies hold a registered product for MUL_LAT cycles; divides run the iterative divider then a sign-fix cycle.
module md_engine
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               hl_we,
  input  logic               hl_sel,
  input  logic               cancel,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;

  md_op_e             op_in;
  logic               in_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod_in;
  logic [WIDTH-1:0]   mag_a, mag_b;

  logic [2*WIDTH-1:0] acc, mul_res;
  logic               div_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   div_hi, div_lo;

  logic               div_load, div_done;
  logic [WIDTH-1:0]   div_quot, div_rem;

  // Launch-side operand preparation; the 2W-bit product of extended operands is exact mod 2^(2W).
  always_comb begin
    op_in     = md_op_e'(md_op);
    in_signed = ~op_is_unsigned(op_in);
    ext_a     = in_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    ext_b     = in_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    prod_in   = ext_a * ext_b;
    mag_a     = (in_signed && opa[WIDTH-1]) ? -opa : opa;
    mag_b     = (in_signed && opb[WIDTH-1]) ? -opb : opb;
  end

  // Completion results. Remainder follows the dividend's sign (truncating division).
  always_comb begin
    acc = {hi_q, lo_q};
    unique case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc + prod_q;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod_q;
      default:           mul_res = prod_q;
    endcase
    div_signed = ~op_is_unsigned(op_q);
    a_neg      = div_signed && a_q[WIDTH-1];
    b_neg      = div_signed && b_q[WIDTH-1];
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end else begin
      div_lo = (a_neg ^ b_neg) ? -div_quot : div_quot;
      div_hi = a_neg ? -div_rem : div_rem;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    if (cancel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d   = op_in;
            a_d    = opa;
            b_d    = opb;
            prod_d = prod_in;
            cnt_d  = '0;
            if (op_is_div(op_in)) begin
              state_d  = ST_DIV;
              div_load = 1'b1;
            end else begin
              state_d = ST_MUL;
            end
          end else if (hl_we) begin
            if (hl_sel) begin
              hi_d = opa;
            end else begin
              lo_d = opa;
            end
          end
        end
        ST_MUL: begin
          if (cnt_q == CNT_LAST) begin
            state_d      = ST_IDLE;
            {hi_d, lo_d} = mul_res;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          hi_d    = div_hi;
          lo_d    = div_lo;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  md_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk     (clk),
    .reset   (reset),
    .load    (div_load),
    .dividend(mag_a),
    .divisor (mag_b),
    .done    (div_done),
    .quot    (div_quot),
    .rem     (div_rem)
  );

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_engine.sv
// Self-checking bench for md_engine: directed scenarios plus randomized ops against an arithmetic model,
// on a 32-bit / 5-cycle-multiply instance and an 8-bit / 1-cycle-multiply instance.
module tb_md_engine;
  import md_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        start, hl_we, hl_sel, cancel, busy;
  logic [2:0]  md_op;
  logic [31:0] opa, opb, hi, lo;

  logic        s_start, s_hl_we, s_hl_sel, s_cancel, s_busy;
  logic [2:0]  s_md_op;
  logic [7:0]  s_opa, s_opb, s_hi, s_lo;

  int          n_checks;
  int          n_fail;
  logic [31:0] m_hi, m_lo;
  logic [31:0] s_m_hi, s_m_lo;

  md_engine #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk), .reset(rst_n), .start(start), .md_op(md_op), .opa(opa), .opb(opb),
    .hl_we(hl_we), .hl_sel(hl_sel), .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  md_engine #(.WIDTH(8), .MUL_LAT(1)) dut8 (
    .clk(clk), .reset(rst_n), .start(s_start), .md_op(s_md_op), .opa(s_opa), .opb(s_opb),
    .hl_we(s_hl_we), .hl_sel(s_hl_sel), .cancel(s_cancel), .busy(s_busy), .hi(s_hi), .lo(s_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic on w-bit HI/LO held in the low bits of 32-bit variables.
  function automatic void ref_op(input int w, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, inout logic [31:0] rhi, inout logic [31:0] rlo);
    logic [63:0] wmask, dmask, acc, res;
    longint      sa, sb, q, r;
    bit          sgn;
    wmask = (64'd1 << w) - 64'd1;
    dmask = (w >= 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
    sgn   = (op[0] == 1'b0);
    sa    = longint'({32'd0, a} & wmask);
    sb    = longint'({32'd0, b} & wmask);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    if (op[2:1] == 2'b01) begin
      if (sb == 0) begin
        rlo = 32'(wmask);
        rhi = 32'({32'd0, a} & wmask);
      end else begin
        q   = sa / sb;
        r   = sa % sb;
        rlo = 32'(q) & 32'(wmask);
        rhi = 32'(r) & 32'(wmask);
      end
    end else begin
      acc = (({32'd0, rhi} & wmask) << w) | ({32'd0, rlo} & wmask);
      res = 64'(sa * sb);
      if (op[2:1] == 2'b10) res = acc + res;
      else if (op[2:1] == 2'b11) res = acc - res;
      res = res & dmask;
      rlo = 32'(res & wmask);
      rhi = 32'((res >> w) & wmask);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
    start = 1'b1; md_op = op; opa = a; opb = b;
    tick();
    start = 1'b0; opa = $urandom; opb = $urandom;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int cycles);
    s_start = 1'b1; s_md_op = op; s_opa = a; s_opb = b;
    tick();
    s_start = 1'b0; s_opa = 8'($urandom); s_opb = 8'($urandom);
    cycles = 0;
    while (s_busy === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic mt32(input logic sel, input logic [31:0] v);
    hl_we = 1'b1; hl_sel = sel; opa = v;
    tick();
    hl_we = 1'b0;
    if (sel) m_hi = v; else m_lo = v;
  endtask

  task automatic mt8(input logic sel, input logic [7:0] v);
    s_hl_we = 1'b1; s_hl_sel = sel; s_opa = v;
    tick();
    s_hl_we = 1'b0;
    if (sel) s_m_hi = {24'd0, v}; else s_m_lo = {24'd0, v};
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (hi !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    n_checks++;
    if (lo !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    n_checks++;
    if (s_busy !== 1'b0 || s_hi !== 8'd0 || s_lo !== 8'd0) begin
      n_fail++; $display("[TB] FAIL reset_w8: got busy=%b hi=%h lo=%h expected 0/00/00", s_busy, s_hi, s_lo);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    m_hi = '0; m_lo = '0; s_m_hi = '0; s_m_lo = '0;
    tick();
  endtask

  task automatic test_mult();
    int cyc;
    run32(OP_MULT, -32'sd3, 32'd7, cyc);
    n_checks++;
    if (cyc != 5) begin n_fail++; $display("[TB] FAIL mult_latency: got %0d expected 5", cyc); end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
    n_checks++;
    if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("[TB] FAIL mult_lo: got %h expected ffffffeb", lo); end
  endtask

  task automatic test_div();
    int cyc;
    run32(OP_DIV, -32'sd7, 32'd2, cyc);
    n_checks++;
    if (cyc != 33) begin n_fail++; $display("[TB] FAIL div_latency: got %0d expected 33", cyc); end
    n_checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      n_fail++; $display("[TB] FAIL div_result: got hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    end
    run32(OP_DIVU, 32'd7, 32'd0, cyc);
    n_checks++;
    if (cyc != 33 || lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
      n_fail++; $display("[TB] FAIL divu_zero: got cyc=%0d hi=%h lo=%h expected 33/00000007/ffffffff", cyc, hi, lo);
    end
    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      n_fail++; $display("[TB] FAIL div_overflow: got hi=%h lo=%h expected 00000000/80000000", hi, lo);
    end
  endtask

  task automatic test_madd();
    int cyc;
    mt32(1'b1, 32'd5);
    mt32(1'b0, 32'd10);
    n_checks++;
    if (hi !== 32'd5 || lo !== 32'd10) begin
      n_fail++; $display("[TB] FAIL mthi_mtlo: got hi=%h lo=%h expected 5/a", hi, lo);
    end
    run32(OP_MADDU, 32'h1_0000, 32'h1_0000, cyc);
    n_checks++;
    if (hi !== 32'd6 || lo !== 32'd10 || cyc != 5) begin
      n_fail++; $display("[TB] FAIL maddu: got hi=%h lo=%h cyc=%0d expected 6/a/5", hi, lo, cyc);
    end
    run32(OP_MSUB, 32'd1, 32'd11, cyc);
    n_checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
      n_fail++; $display("[TB] FAIL msub: got hi=%h lo=%h expected 5/ffffffff", hi, lo);
    end
    m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_cancel();
    int          cyc;
    logic [31:0] a, b;
    mt32(1'b1, $urandom);
    mt32(1'b0, $urandom);
    start = 1'b1; md_op = OP_DIV; opa = 32'd100; opb = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel_busy_before: got %b expected 1", busy); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("[TB] FAIL cancel_div: got busy=%b hi=%h lo=%h expected 0/%h/%h", busy, hi, lo, m_hi, m_lo);
    end
    a = $urandom; b = $urandom;
    run32(OP_MULT, a, b, cyc);
    ref_op(32, OP_MULT, a, b, m_hi, m_lo);
    n_checks++;
    if (cyc != 5 || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("[TB] FAIL mult_after_cancel: got cyc=%0d hi=%h lo=%h expected 5/%h/%h", cyc, hi, lo, m_hi, m_lo);
    end
    start = 1'b1; md_op = OP_MADDU; opa = $urandom; opb = $urandom;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("[TB] FAIL cancel_at_completion: got busy=%b hi=%h lo=%h expected 0/%h/%h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [31:0] a, b;
    mt32(1'b1, $urandom);
    mt32(1'b0, $urandom);
    a = $urandom; b = $urandom;
    start = 1'b1; md_op = OP_MADD; opa = a; opb = b;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      start = (cyc == 2); hl_we = (cyc == 2); hl_sel = 1'b1;
      md_op = OP_DIVU; opa = $urandom; opb = $urandom;
      tick();
    end
    start = 1'b0; hl_we = 1'b0;
    ref_op(32, OP_MADD, a, b, m_hi, m_lo);
    n_checks++;
    if (cyc != 5 || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("[TB] FAIL ignore_while_busy: got cyc=%0d hi=%h lo=%h expected 5/%h/%h", cyc, hi, lo, m_hi, m_lo);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL dropped_start: got busy=%b expected 0", busy); end
    start = 1'b1; cancel = 1'b1; md_op = OP_MULT; opa = $urandom; opb = $urandom;
    tick();
    start = 1'b0; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL start_with_cancel: got busy=%b expected 0", busy); end
    repeat (6) tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("[TB] FAIL start_with_cancel_hilo: got busy=%b hi=%h lo=%h expected 0/%h/%h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_async_reset();
    mt32(1'b1, 32'h1234_5678);
    mt32(1'b0, 32'h9ABC_DEF0);
    start = 1'b1; md_op = OP_DIV; opa = $urandom; opb = 32'd9;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("[TB] FAIL async_reset: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    m_hi = '0; m_lo = '0; s_m_hi = '0; s_m_lo = '0;
    tick();
  endtask

  task automatic test_random32();
    int          cyc, lat;
    logic [2:0]  op;
    logic [31:0] a, b;
    mt32(1'b1, $urandom);
    mt32(1'b0, $urandom);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) mt32(1'($urandom_range(0, 1)), $urandom);
      lat = (op[2:1] == 2'b01) ? 33 : 5;
      run32(op, a, b, cyc);
      ref_op(32, op, a, b, m_hi, m_lo);
      n_checks++;
      if (cyc != lat) begin n_fail++; $display("[TB] FAIL rand32_latency op=%0d: got %0d expected %0d", op, cyc, lat); end
      n_checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("[TB] FAIL rand32_result op=%0d a=%h b=%h: got hi=%h lo=%h expected %h/%h", op, a, b, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_random8();
    int         cyc, lat;
    logic [2:0] op;
    logic [7:0] a, b;
    mt8(1'b1, 8'($urandom));
    mt8(1'b0, 8'($urandom));
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      case ($urandom_range(0, 5))
        0: b = 8'd0;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = 8'($urandom_range(1, 5));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) mt8(1'($urandom_range(0, 1)), 8'($urandom));
      lat = (op[2:1] == 2'b01) ? 9 : 1;
      run8(op, a, b, cyc);
      ref_op(8, op, {24'd0, a}, {24'd0, b}, s_m_hi, s_m_lo);
      n_checks++;
      if (cyc != lat) begin n_fail++; $display("[TB] FAIL rand8_latency op=%0d: got %0d expected %0d", op, cyc, lat); end
      n_checks++;
      if (s_hi !== s_m_hi[7:0] || s_lo !== s_m_lo[7:0]) begin
        n_fail++;
        $display("[TB] FAIL rand8_result op=%0d a=%h b=%h: got hi=%h lo=%h expected %h/%h",
                 op, a, b, s_hi, s_lo, s_m_hi[7:0], s_m_lo[7:0]);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    start = 1'b0; hl_we = 1'b0; hl_sel = 1'b0; cancel = 1'b0; md_op = 3'd0; opa = '0; opb = '0;
    s_start = 1'b0; s_hl_we = 1'b0; s_hl_sel = 1'b0; s_cancel = 1'b0; s_md_op = 3'd0; s_opa = '0; s_opb = '0;
    m_hi = '0; m_lo = '0; s_m_hi = '0; s_m_lo = '0;
    $display("[TB] starting md_engine bench");
    test_reset();
    test_mult();
    test_div();
    test_madd();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    test_random32();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
